// File: rtl/pdm_decimator.sv
// pdm_decimator
// PDM microphone front-end: generates the microphone clock, samples the
// 1-bit stream through a synchroniser, decimates it with a 3rd-order CIC
// filter and presents signed PCM samples on a valid/ready interface.
// Lowering en holds the block idle and flushes the whole filter pipeline.

module pdm_decimator #(
    parameter int CLK_DIV = 8,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    output logic                    pdm_clk,
    input  logic                    pdm_data,
    output logic signed [OUT_W-1:0] sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int LOG_D = $clog2(DECIM);
    localparam int W     = 3 * LOG_D + 2;
    localparam int DW    = $clog2(CLK_DIV);
    localparam int EW    = W + OUT_W;

    // Net right shift taking the CIC gain DECIM^3 down to OUT_W bits; for
    // small DECIM the net shift is to the left instead.
    localparam int SHIFT_NET = 3 * LOG_D - (OUT_W - 1);
    localparam int SHIFT_R   = (SHIFT_NET > 0) ? SHIFT_NET : 0;
    localparam int SHIFT_L   = (SHIFT_NET < 0) ? -SHIFT_NET : 0;

    localparam logic [DW-1:0]    DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]    DIV_HALF  = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0]    DIV_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0]    DIV_ONE   = DW'(1);
    localparam logic [LOG_D-1:0] DCNT_LAST = LOG_D'(DECIM - 1);
    localparam logic [LOG_D-1:0] DCNT_ZERO = {LOG_D{1'b0}};
    localparam logic [LOG_D-1:0] DCNT_ONE  = LOG_D'(1);

    localparam logic signed [W-1:0] ACC_ZERO = {W{1'b0}};
    localparam logic signed [W-1:0] ACC_POS1 = W'(1);
    localparam logic signed [W-1:0] ACC_NEG1 = {W{1'b1}};

    localparam logic signed [EW-1:0] SAT_MAX =
        {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN =
        {{(EW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Outputs before this many comb results are dropped while the filter fills.
    localparam logic [1:0] WARM_DONE = 2'd3;

    // ------------------------------------------------------------------
    // Scale the comb result down to OUT_W bits and clamp to the output range
    // ------------------------------------------------------------------
    function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [W-1:0] r);
        logic signed [EW-1:0] e;
        logic signed [OUT_W-1:0] res;
        e = {{OUT_W{r[W-1]}}, r};
        e = e >>> SHIFT_R;
        e = e <<< SHIFT_L;
        if (e > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (e < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = e[OUT_W-1:0];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]           div_r;
    logic                    pdm_clk_r;
    logic                    sync1_r;
    logic                    sync2_r;
    logic [LOG_D-1:0]        dcnt_r;
    logic signed [W-1:0]     integ1_r;
    logic signed [W-1:0]     integ2_r;
    logic signed [W-1:0]     integ3_r;
    logic                    comb_go_r;
    logic signed [W-1:0]     dly1_r;
    logic signed [W-1:0]     dly2_r;
    logic signed [W-1:0]     dly3_r;
    logic [1:0]              warm_r;
    logic signed [OUT_W-1:0] sample_r;
    logic                    sample_valid_r;
    logic                    overrun_r;

    logic [DW-1:0]           div_next_s;
    logic                    tick_s;
    logic                    dec_pt_s;
    logic signed [W-1:0]     pdm_val_s;
    logic signed [W-1:0]     comb1_s;
    logic signed [W-1:0]     comb2_s;
    logic signed [W-1:0]     comb3_s;
    logic signed [OUT_W-1:0] scaled_s;
    logic                    new_sample_s;

    // Next divider value: wraps at CLK_DIV-1, held at zero while disabled
    always_comb begin
        div_next_s = DIV_ZERO;
        if (!en) begin
            div_next_s = DIV_ZERO;
        end else if (div_r == DIV_LAST) begin
            div_next_s = DIV_ZERO;
        end else begin
            div_next_s = div_r + DIV_ONE;
        end
    end

    // PDM tick, decimation point and the +1/-1 mapping of the sampled bit
    always_comb begin
        tick_s    = en && (div_r == DIV_LAST);
        dec_pt_s  = tick_s && (dcnt_r == DCNT_LAST);
        pdm_val_s = ACC_ZERO;
        if (sync2_r) begin
            pdm_val_s = ACC_POS1;
        end else begin
            pdm_val_s = ACC_NEG1;
        end
    end

    // Comb differentiators on the integrator-3 output, then scaling
    always_comb begin
        comb1_s      = integ3_r - dly1_r;
        comb2_s      = comb1_s - dly2_r;
        comb3_s      = comb2_s - dly3_r;
        scaled_s     = scale_sat(comb3_s);
        new_sample_s = comb_go_r && (warm_r == WARM_DONE);
    end

    // Clock divider and registered microphone clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= DIV_ZERO;
            pdm_clk_r <= 1'b0;
        end else begin
            div_r     <= div_next_s;
            pdm_clk_r <= en && (div_next_s < DIV_HALF);
        end
    end

    // Two-flop synchroniser for the asynchronous microphone data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pdm_data;
            sync2_r <= sync1_r;
        end
    end

    // Integrator cascade and decimation counter, advanced once per PDM tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ1_r  <= ACC_ZERO;
            integ2_r  <= ACC_ZERO;
            integ3_r  <= ACC_ZERO;
            dcnt_r    <= DCNT_ZERO;
            comb_go_r <= 1'b0;
        end else if (!en) begin
            integ1_r  <= ACC_ZERO;
            integ2_r  <= ACC_ZERO;
            integ3_r  <= ACC_ZERO;
            dcnt_r    <= DCNT_ZERO;
            comb_go_r <= 1'b0;
        end else begin
            comb_go_r <= dec_pt_s;
            if (tick_s) begin
                // Wrap-around arithmetic is intended; the combs undo it.
                integ1_r <= integ1_r + pdm_val_s;
                integ2_r <= integ2_r + integ1_r;
                integ3_r <= integ3_r + integ2_r;
                if (dcnt_r == DCNT_LAST) begin
                    dcnt_r <= DCNT_ZERO;
                end else begin
                    dcnt_r <= dcnt_r + DCNT_ONE;
                end
            end else begin
                integ1_r <= integ1_r;
                integ2_r <= integ2_r;
                integ3_r <= integ3_r;
                dcnt_r   <= dcnt_r;
            end
        end
    end

    // Comb delay line and warm-up counter, advanced once per decimated sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly1_r <= ACC_ZERO;
            dly2_r <= ACC_ZERO;
            dly3_r <= ACC_ZERO;
            warm_r <= 2'd0;
        end else if (!en) begin
            dly1_r <= ACC_ZERO;
            dly2_r <= ACC_ZERO;
            dly3_r <= ACC_ZERO;
            warm_r <= 2'd0;
        end else if (comb_go_r) begin
            dly1_r <= integ3_r;
            dly2_r <= comb1_s;
            dly3_r <= comb2_s;
            if (warm_r != WARM_DONE) begin
                warm_r <= warm_r + 2'd1;
            end else begin
                warm_r <= warm_r;
            end
        end else begin
            dly1_r <= dly1_r;
            dly2_r <= dly2_r;
            dly3_r <= dly3_r;
            warm_r <= warm_r;
        end
    end

    // Output register with valid/ready handshake and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r       <= {OUT_W{1'b0}};
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (!en) begin
            // The last sample value is kept so the consumer can still read it.
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (new_sample_s) begin
            sample_r       <= scaled_s;
            sample_valid_r <= 1'b1;
            // Replacing an untaken sample loses it; a same-cycle transfer does not.
            if (sample_valid_r && !sample_ready) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (sample_valid_r && sample_ready) begin
            sample_valid_r <= 1'b0;
        end else begin
            sample_valid_r <= sample_valid_r;
        end
    end

    assign pdm_clk      = pdm_clk_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator at default parameters.
// Expected samples go into a queue when a stimulus pattern is started and
// are popped when the DUT hands a sample over.

module tb_pdm_decimator;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               pdm_data;
    logic               sample_ready;
    logic               pdm_clk;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic signed [15:0] exp_q[$];

    logic [3:0] pat;
    int         pat_len;

    localparam logic signed [15:0] S_MAX  = 16'sh7FFF;
    localparam logic signed [15:0] S_MIN  = 16'sh8000;
    localparam logic signed [15:0] S_HALF = 16'sd16384;
    localparam logic signed [15:0] S_ZERO = 16'sd0;
    localparam int FIRST_AT = 2048;   // edges after en rise: 4th decimation point + 2
    localparam int PERIOD   = 512;

    pdm_decimator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Microphone model: presents the next pattern bit just after each pdm_clk rise
    initial begin
        int pidx;
        pidx = 0;
        pdm_data = 1'b0;
        forever begin
            @(posedge pdm_clk);
            #1;
            pdm_data = pat[pidx % pat_len];
            pidx = pidx + 1;
        end
    end

    // Flush with en low, select a pattern, raise en at a falling edge
    task automatic start_run(input logic [3:0] p, input int len, output int c0);
        @(negedge clk);
        en = 1'b0;
        pat = p;
        pat_len = len;
        @(negedge clk);
        en = 1'b1;
        c0 = cyc;
    endtask

    // Wait for a transfer (valid && ready) within a cycle budget
    task automatic wait_xfer(input int budget, output bit got,
                             output logic signed [15:0] val, output int vcyc);
        int i;
        got = 1'b0;
        val = 16'sd0;
        vcyc = 0;
        i = 0;
        while (!got && i < budget) begin
            @(posedge clk);
            #1;
            if (sample_valid && sample_ready) begin
                got = 1'b1;
                val = sample;
                vcyc = cyc;
            end
            i = i + 1;
        end
    endtask

    // Wait for sample_valid regardless of ready within a cycle budget
    task automatic wait_valid(input int budget, output bit got, output int vcyc);
        int i;
        got = 1'b0;
        vcyc = 0;
        i = 0;
        while (!got && i < budget) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                got = 1'b1;
                vcyc = cyc;
            end
            i = i + 1;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (pdm_clk !== 1'b0)      begin n_err++; $display("FAIL reset_pdm_clk got %0b want 0", pdm_clk); end
        n_cmp++; if (sample !== 16'sd0)     begin n_err++; $display("FAIL reset_sample got %0d want 0", sample); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", sample_valid); end
        n_cmp++; if (overrun !== 1'b0)      begin n_err++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    endtask

    task automatic test_const_one;
        int c0, vcyc, prev_cyc, r1, r2, high;
        bit got;
        logic signed [15:0] val, e;
        logic pc[32];
        sample_ready = 1'b1;
        start_run(4'b0001, 1, c0);
        for (int k = 0; k < 4; k++) exp_q.push_back(S_MAX);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            pc[i] = pdm_clk;
        end
        r1 = -1; r2 = -1;
        for (int i = 8; i < 32; i++) begin
            if (pc[i] && !pc[i-1]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        high = 0;
        if (r1 >= 0 && r2 > r1) begin
            for (int i = r1; i < r2; i++) if (pc[i]) high++;
        end
        n_cmp++; if (r2 - r1 !== 8) begin n_err++; $display("FAIL pdm_clk_period got %0d want 8", r2 - r1); end
        n_cmp++; if (high !== 4)    begin n_err++; $display("FAIL pdm_clk_high got %0d want 4", high); end
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_xfer((k == 0) ? 2200 : 700, got, val, vcyc);
            if (!got) begin
                n_cmp++; n_err++; $display("FAIL const1_timeout sample %0d got none want a transfer", k);
            end else begin
                if (k == 0) begin
                    n_cmp++;
                    if (vcyc - c0 - 1 !== FIRST_AT) begin n_err++; $display("FAIL const1_first_valid got %0d want %0d", vcyc - c0 - 1, FIRST_AT); end
                end else begin
                    n_cmp++;
                    if (vcyc - prev_cyc !== PERIOD) begin n_err++; $display("FAIL const1_spacing got %0d want %0d", vcyc - prev_cyc, PERIOD); end
                end
                prev_cyc = vcyc;
                e = exp_q.pop_front();
                n_cmp++; if (val !== e) begin n_err++; $display("FAIL const1_value got %0d want %0d", val, e); end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_patterns;
        int c0, vcyc;
        bit got;
        logic signed [15:0] val, e;
        logic [3:0] pats[3];
        int lens[3];
        logic signed [15:0] exps[3];
        pats[0] = 4'b0000; lens[0] = 1; exps[0] = S_MIN;
        pats[1] = 4'b0101; lens[1] = 2; exps[1] = S_ZERO;
        pats[2] = 4'b0111; lens[2] = 4; exps[2] = S_HALF;
        sample_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            start_run(pats[p], lens[p], c0);
            exp_q.push_back(exps[p]);
            exp_q.push_back(exps[p]);
            for (int k = 0; k < 2; k++) begin
                wait_xfer((k == 0) ? 2200 : 700, got, val, vcyc);
                if (!got) begin
                    n_cmp++; n_err++; $display("FAIL pattern%0d_timeout got none want a transfer", p);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if (val !== e) begin n_err++; $display("FAIL pattern%0d_value got %0d want %0d", p, val, e); end
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure;
        int c0, v1, off, unstable;
        bit got;
        logic signed [15:0] s1, e;
        logic ov_before;
        sample_ready = 1'b0;
        start_run(4'b0001, 1, c0);
        exp_q.push_back(S_MAX);
        exp_q.push_back(S_MAX);
        wait_valid(2200, got, v1);
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL bp_timeout got none want valid");
        end else begin
            s1 = sample;
            e = exp_q.pop_front();
            n_cmp++; if (s1 !== e)         begin n_err++; $display("FAIL bp_first_value got %0d want %0d", s1, e); end
            n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_overrun_early got %0b want 0", overrun); end
            unstable = 0;
            ov_before = 1'bx;
            for (int k = 0; k < 516; k++) begin
                @(posedge clk);
                #1;
                off = cyc - v1;
                if (off < PERIOD && (!sample_valid || sample !== s1)) unstable++;
                if (off == PERIOD - 1) ov_before = overrun;
            end
            n_cmp++; if (unstable !== 0)      begin n_err++; $display("FAIL bp_hold got %0d unstable cycles want 0", unstable); end
            n_cmp++; if (ov_before !== 1'b0)  begin n_err++; $display("FAIL bp_overrun_before_2nd got %0b want 0", ov_before); end
            n_cmp++; if (sample_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_after_2nd got %0b want 1", sample_valid); end
            n_cmp++; if (overrun !== 1'b1)    begin n_err++; $display("FAIL bp_overrun_after_2nd got %0b want 1", overrun); end
            @(negedge clk);
            sample_ready = 1'b1;
            s1 = sample;
            e = exp_q.pop_front();
            n_cmp++; if (s1 !== e) begin n_err++; $display("FAIL bp_xfer_value got %0d want %0d", s1, e); end
            @(posedge clk);
            #1;
            n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop got %0b want 0", sample_valid); end
            n_cmp++; if (overrun !== 1'b1)      begin n_err++; $display("FAIL bp_overrun_sticky got %0b want 1", overrun); end
        end
        exp_q.delete();
    endtask

    task automatic test_en_drop;
        int c0, vcyc;
        bit got;
        logic signed [15:0] val, e;
        @(negedge clk);
        sample_ready = 1'b0;
        wait_valid(700, got, vcyc);
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL endrop_timeout got none want valid");
        end else begin
            @(negedge clk);
            en = 1'b0;
            @(posedge clk);
            #1;
            n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL endrop_valid got %0b want 0", sample_valid); end
            n_cmp++; if (pdm_clk !== 1'b0)      begin n_err++; $display("FAIL endrop_pdm_clk got %0b want 0", pdm_clk); end
            n_cmp++; if (overrun !== 1'b0)      begin n_err++; $display("FAIL endrop_overrun got %0b want 0", overrun); end
            n_cmp++; if (sample !== S_MAX)      begin n_err++; $display("FAIL endrop_sample_kept got %0d want %0d", sample, S_MAX); end
        end
        sample_ready = 1'b1;
        start_run(4'b0001, 1, c0);
        exp_q.push_back(S_MAX);
        wait_xfer(2200, got, val, vcyc);
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL reen_timeout got none want a transfer");
        end else begin
            n_cmp++; if (vcyc - c0 - 1 !== FIRST_AT) begin n_err++; $display("FAIL reen_first_valid got %0d want %0d", vcyc - c0 - 1, FIRST_AT); end
            e = exp_q.pop_front();
            n_cmp++; if (val !== e) begin n_err++; $display("FAIL reen_value got %0d want %0d", val, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_rst_mid;
        int c0, vcyc;
        bit got;
        logic signed [15:0] val, e;
        sample_ready = 1'b0;
        start_run(4'b0001, 1, c0);
        wait_valid(2200, got, vcyc);
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL rst_timeout got none want valid");
        end
        repeat (100) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sample !== 16'sd0)     begin n_err++; $display("FAIL rst_async_sample got %0d want 0", sample); end
        n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got %0b want 0", sample_valid); end
        n_cmp++; if (pdm_clk !== 1'b0)      begin n_err++; $display("FAIL rst_async_pdm_clk got %0b want 0", pdm_clk); end
        n_cmp++; if (overrun !== 1'b0)      begin n_err++; $display("FAIL rst_async_overrun got %0b want 0", overrun); end
        @(negedge clk);
        @(negedge clk);
        sample_ready = 1'b1;
        rst_n = 1'b1;
        c0 = cyc;
        exp_q.push_back(S_MAX);
        wait_xfer(2200, got, val, vcyc);
        if (!got) begin
            n_cmp++; n_err++; $display("FAIL rst_rel_timeout got none want a transfer");
        end else begin
            n_cmp++; if (vcyc - c0 - 1 !== FIRST_AT) begin n_err++; $display("FAIL rst_rel_first_valid got %0d want %0d", vcyc - c0 - 1, FIRST_AT); end
            e = exp_q.pop_front();
            n_cmp++; if (val !== e) begin n_err++; $display("FAIL rst_rel_value got %0d want %0d", val, e); end
        end
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        sample_ready = 1'b0;
        pat = 4'b0001;
        pat_len = 1;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_const_one();
        test_patterns();
        test_backpressure();
        test_en_drop();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
